// File: rtl/baud_pkg.sv
// Shared constants and types for the programmable baud tick generator.
// Build option: BAUD_FRAC_EN enables the fractional divisor in baud_gen_prog.
package baud_pkg;

    // Default field widths of a divisor word.
    localparam int BAUD_DIV_W  = 16;
    localparam int BAUD_FRAC_W = 4;

    // Smallest integer divisor the generator will run with.
    localparam int DIV_MIN = 2;

    // Divisor loaded at reset: 50 MHz / (9600 * 16) ~= 325.5.
    localparam int BAUD_DEFAULT_DIV = 326;

    // Divisor word as written over div_in: integer part on top, fraction in the low bits.
    typedef struct packed {
        logic [BAUD_DIV_W-1:0]  int_part;
        logic [BAUD_FRAC_W-1:0] frac;
    } div_word_t;

    // Ready-made divisor words for a 50 MHz sysclk and 16x oversampling.
    // Each is floor(50e6 * 16 / (baud * 16)) split into {integer, sixteenths}.
    localparam div_word_t DIV_9600   = {16'd325, 4'd8};   // 325.50
    localparam div_word_t DIV_19200  = {16'd162, 4'd12};  // 162.75
    localparam div_word_t DIV_115200 = {16'd27,  4'd2};   //  27.125

    // Divisor word for an arbitrary clock and rate, fraction in 1/16 steps.
    function automatic div_word_t make_div(input longint unsigned clk_hz,
                                           input longint unsigned baud,
                                           input longint unsigned ovs);
        longint unsigned q;
        div_word_t       w;
        q          = (clk_hz * 64'd16) / (baud * ovs);
        w.int_part = q[BAUD_DIV_W+BAUD_FRAC_W-1:BAUD_FRAC_W];
        w.frac     = q[BAUD_FRAC_W-1:0];
        return w;
    endfunction

endpackage

// File: rtl/baud_gen_prog_if.sv
// Control/status bundle between a UART controller and baud_gen_prog.
// Build option: BAUD_FRAC_EN (in baud_gen_prog) gives the div_in fraction field meaning.
interface baud_gen_prog_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    // Signalling: there is no valid/ready pair here. enable is a level; resync and
    // div_wr are single-cycle strobes that always take effect at the edge they are
    // sampled on (no back-pressure). div_pending is a level that stays high from the
    // div_wr edge until the captured divisor becomes active. os_tick and bit_tick are
    // single-cycle pulses; BaudRate_clk is a free-running level.
    logic                    enable;
    logic                    resync;
    logic                    div_wr;
    logic [DIV_W+FRAC_W-1:0] div_in;
    logic                    div_pending;
    logic                    os_tick;
    logic                    bit_tick;
    logic                    BaudRate_clk;

    modport master (
        output enable, resync, div_wr, div_in,
        input  div_pending, os_tick, bit_tick, BaudRate_clk
    );

    modport slave (
        input  enable, resync, div_wr, div_in,
        output div_pending, os_tick, bit_tick, BaudRate_clk
    );
endinterface

// File: rtl/baud_os_counter.sv
// Oversample counter: counts os_tick events and flags every OVERSAMPLE-th one as a
// bit tick. Shared with the RX sampler, which uses o_os_cnt as its sample phase.
module baud_os_counter #(
    parameter int OVERSAMPLE = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_tick,
    input  logic                          i_clear,
    input  logic                          i_enable,
    output logic [$clog2(OVERSAMPLE)-1:0] o_os_cnt,
    output logic                          o_bit_tick
);
    localparam int                    CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_os_cnt;
    logic             r_bit_tick;

    // Advance on each tick event; the wrap from the last count emits bit_tick
    // in the same cycle as the matching os_tick.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_os_cnt   <= '0;
            r_bit_tick <= 1'b0;
        end else if (i_clear) begin
            r_os_cnt   <= '0;
            r_bit_tick <= 1'b0;
        end else if (!i_enable) begin
            r_bit_tick <= 1'b0;
        end else if (i_tick) begin
            if (r_os_cnt == CNT_LAST) begin
                r_os_cnt   <= '0;
                r_bit_tick <= 1'b1;
            end else begin
                r_os_cnt   <= r_os_cnt + CNT_ONE;
                r_bit_tick <= 1'b0;
            end
        end else begin
            r_bit_tick <= 1'b0;
        end
    end

    assign o_os_cnt   = r_os_cnt;
    assign o_bit_tick = r_bit_tick;

endmodule

// File: rtl/baud_gen_prog.sv
// Runtime-programmable baud tick generator: divides sysclk by a loadable divisor into
// an oversample tick, a bit tick every OVERSAMPLE oversample ticks, and a legacy
// square-wave oversample clock. Divisor changes only land on period boundaries,
// resync or while frozen, so a running period is never cut short or stretched.
// Build option: define BAUD_FRAC_EN to honour the div_in fraction bits.
module baud_gen_prog
    import baud_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV
) (
    input logic            sysclk,
    input logic            reset,
    baud_gen_prog_if.slave bif
);
    localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);
    localparam logic [DIV_W:0]   PER_ONE   = (DIV_W+1)'(1);

    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_pend_int;
    logic             r_div_pending;
    logic             r_os_tick;
    logic             r_brclk;

    logic [DIV_W:0]   w_period;
    logic [DIV_W:0]   w_half;
    logic             w_term;
    logic             w_apply;
    logic [DIV_W-1:0] w_in_int;
    logic [DIV_W-1:0] w_in_int_clamped;
    logic             w_bit_tick;
    logic [$clog2(OVERSAMPLE)-1:0] w_os_cnt_unused;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] r_frac_act;
    logic [FRAC_W-1:0] r_pend_frac;
    logic [FRAC_W-1:0] r_frac_acc;
    logic              r_carry;

    // A carry out of the fraction accumulator lengthens the following period by one.
    assign w_period = {1'b0, r_div_act} + {{DIV_W{1'b0}}, r_carry};
`else
    logic w_frac_unused;

    // Integer-only build: the fraction field is accepted on the bus but has no effect.
    assign w_frac_unused = ^bif.div_in[FRAC_W-1:0];
    assign w_period      = {1'b0, r_div_act};
`endif

    assign w_half = w_period >> 1;

    // Terminal count. The >= keeps the divider from running away if a smaller divisor
    // was applied while the counter was frozen past the new terminal value.
    assign w_term = bif.enable && ({1'b0, r_count} >= (w_period - PER_ONE));

    // A captured divisor goes live at a period boundary, on resync, or while frozen.
    assign w_apply = r_div_pending && (w_term || bif.resync || !bif.enable);

    // Integer parts below the minimum are raised to it when captured.
    assign w_in_int         = bif.div_in[DIV_W+FRAC_W-1:FRAC_W];
    assign w_in_int_clamped = (w_in_int < DIV_FLOOR) ? DIV_FLOOR : w_in_int;

    // Main divider: period counter, oversample tick and the legacy square wave.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            r_count   <= '0;
            r_os_tick <= 1'b0;
            r_brclk   <= 1'b0;
        end else if (bif.resync) begin
            r_count   <= '0;
            r_os_tick <= 1'b0;
            r_brclk   <= 1'b0;
        end else if (bif.enable) begin
            r_os_tick <= w_term;
            r_count   <= w_term ? '0 : (r_count + CNT_ONE);
            r_brclk   <= ({1'b0, r_count} < w_half);
        end else begin
            r_os_tick <= 1'b0;
        end
    end

    // Divisor staging: capture on div_wr, promote to active on apply. When both happen
    // in one edge the old staged value goes live and the new one stays pending.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            r_div_act     <= DIV_RST;
            r_pend_int    <= DIV_RST;
            r_div_pending <= 1'b0;
        end else begin
            if (w_apply) begin
                r_div_act <= r_pend_int;
            end
            if (bif.div_wr) begin
                r_pend_int <= w_in_int_clamped;
            end
            if (bif.div_wr) begin
                r_div_pending <= 1'b1;
            end else if (w_apply) begin
                r_div_pending <= 1'b0;
            end
        end
    end

`ifdef BAUD_FRAC_EN
    // Fraction path: staged alongside the integer part, accumulated once per period.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            r_frac_act  <= '0;
            r_pend_frac <= '0;
            r_frac_acc  <= '0;
            r_carry     <= 1'b0;
        end else begin
            if (w_apply) begin
                r_frac_act <= r_pend_frac;
            end
            if (bif.div_wr) begin
                r_pend_frac <= bif.div_in[FRAC_W-1:0];
            end
            if (bif.resync) begin
                r_frac_acc <= '0;
                r_carry    <= 1'b0;
            end else if (w_term) begin
                {r_carry, r_frac_acc} <= {1'b0, r_frac_acc} + {1'b0, r_frac_act};
            end
        end
    end
`endif

    baud_os_counter #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_os_counter (
        .i_clk      (sysclk),
        .i_rst_n    (reset),
        .i_tick     (w_term),
        .i_clear    (bif.resync),
        .i_enable   (bif.enable),
        .o_os_cnt   (w_os_cnt_unused),
        .o_bit_tick (w_bit_tick)
    );

    assign bif.div_pending  = r_div_pending;
    assign bif.os_tick      = r_os_tick;
    assign bif.bit_tick     = w_bit_tick;
    assign bif.BaudRate_clk = r_brclk;

endmodule
